// File: rtl/key_press_conditioner_pkg.sv
// Shared definitions for the key conditioner and the lock it feeds:
// FSM state encodings and the one-hot test both blocks rely on.
package key_press_conditioner_pkg;

    localparam int unsigned KEY_W = 4;

    typedef enum logic [1:0] {
        IDLE             = 2'd0,
        DEBOUNCE_PRESS   = 2'd1,
        HELD             = 2'd2,
        DEBOUNCE_RELEASE = 2'd3
    } kpc_state_e;

    // True when exactly one bit of v is set.
    function automatic logic is_one_hot(input logic [KEY_W-1:0] v);
        return (v != '0) && ((v & (v - KEY_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchroniser for asynchronous active-low buttons; resets to the
// released (all-ones) level so no press is seen while reset is active.
module key_sync #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] synced
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta   <= '1;
            synced <= '1;
        end else begin
            meta   <= raw;
            synced <= meta;
        end
    end

endmodule

// File: rtl/key_press_conditioner.sv
// Turns four raw bouncing active-low buttons into one-cycle one-hot press
// pulses; chorded presses produce a single key_reject pulse instead.
module key_press_conditioner
    import key_press_conditioner_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ      = 50,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [KEY_W-1:0] key_n,
    output logic [KEY_W-1:0] key,
    output logic             key_reject
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES < 2 || CLOCK_FREQ == 0) begin : g_bad_param
            $error("key_press_conditioner: DEBOUNCE_CYCLES must be >= 2 and CLOCK_FREQ nonzero");
        end
    endgenerate

    logic [KEY_W-1:0] synced;
    logic [KEY_W-1:0] sync;
    logic [KEY_W-1:0] candidate;
    logic [CNT_W-1:0] cnt;
    kpc_state_e       state;

    key_sync #(
        .WIDTH (KEY_W)
    ) u_key_sync (
        .clock  (clock),
        .reset  (reset),
        .raw    (key_n),
        .synced (synced)
    );

    assign sync = ~synced;

    // Debounce FSM: press needs DEBOUNCE_CYCLES identical samples, release
    // needs DEBOUNCE_CYCLES zero samples before another press is accepted.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            candidate  <= '0;
            key        <= '0;
            key_reject <= 1'b0;
        end else begin
            key        <= '0;
            key_reject <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (sync != '0) begin
                        candidate <= sync;
                        cnt       <= CNT_ONE;
                        state     <= DEBOUNCE_PRESS;
                    end
                end
                DEBOUNCE_PRESS: begin
                    if (sync == '0) begin
                        state <= IDLE;
                    end else if (sync != candidate) begin
                        candidate <= sync;
                        cnt       <= CNT_ONE;
                    end else if (cnt < CNT_LAST) begin
                        cnt <= cnt + CNT_ONE;
                    end else begin
                        if (is_one_hot(candidate)) begin
                            key <= candidate;
                        end else begin
                            key_reject <= 1'b1;
                        end
                        state <= HELD;
                    end
                end
                HELD: begin
                    if (sync == '0) begin
                        cnt   <= CNT_ONE;
                        state <= DEBOUNCE_RELEASE;
                    end
                end
                DEBOUNCE_RELEASE: begin
                    if (sync != '0) begin
                        state <= HELD;
                    end else if (cnt < CNT_LAST) begin
                        cnt <= cnt + CNT_ONE;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
